// File: rtl/instr_issuer_pkg.sv
// Shared constants for the instruction issuer: FSM encodings, default depth, opcodes.
package instr_issuer_pkg;

    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned LEN_W     = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h9;
    localparam logic [3:0] OP_ADD  = 4'hA;
    localparam logic [3:0] OP_SUB  = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_NOT  = 4'hE;
    localparam logic [3:0] OP_XOR  = 4'hF;

    // An entry whose opcode nibble is NOP terminates a program load.
    function automatic logic is_nop(input logic [BYTE_W-1:0] hi_byte);
        return hi_byte[7:4] == OP_NOP;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Program register file: one synchronous write port, one combinational read port, no reset.
module instr_mem
    import instr_issuer_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [INSTR_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [INSTR_W-1:0]   rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Write port; contents survive reset so a program persists until reloaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Loads a byte-serial program, then issues it to a compute unit and collects one result per entry.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 load,
    input  logic                 start,
    input  logic [BYTE_W-1:0]    byte_in,
    input  logic                 byte_valid,
    input  logic [BYTE_W-1:0]    result_in,
    output logic [INSTR_W-1:0]   instr_out,
    output logic                 cu_ena,
    output logic                 busy,
    output logic [LEN_W-1:0]     prog_len,
    output logic [BYTE_W-1:0]    result_out,
    output logic                 result_valid,
    output logic [BYTE_W-1:0]    acc_out,
    output logic                 done
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state_q,        state_d;
    logic [PTR_W-1:0]    wr_ptr_q,       wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,       rd_ptr_d;
    logic                phase_q,        phase_d;
    logic [BYTE_W-1:0]   hi_q,           hi_d;
    logic [LEN_W-1:0]    prog_len_q,     prog_len_d;
    logic                drain_q,        drain_d;
    logic [INSTR_W-1:0]  instr_q,        instr_d;
    logic                cu_ena_q,       cu_ena_d;
    logic                cap_pend_q,     cap_pend_d;
    logic [BYTE_W-1:0]   result_q,       result_d;
    logic                result_valid_q, result_valid_d;
    logic [BYTE_W-1:0]   acc_q,          acc_d;
    logic                done_q,         done_d;
    logic                busy_q,         busy_d;

    logic                mem_we_c;
    logic [INSTR_W-1:0]  mem_wdata_c;
    logic [INSTR_W-1:0]  mem_rdata_c;

    assign mem_wdata_c = {hi_q, byte_in};

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c & ena),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata_c),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata_c)
    );

    // State register and all output registers; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            phase_q        <= 1'b0;
            hi_q           <= '0;
            prog_len_q     <= '0;
            drain_q        <= 1'b0;
            instr_q        <= '0;
            cu_ena_q       <= 1'b0;
            cap_pend_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            acc_q          <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else if (ena) begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            phase_q        <= phase_d;
            hi_q           <= hi_d;
            prog_len_q     <= prog_len_d;
            drain_q        <= drain_d;
            instr_q        <= instr_d;
            cu_ena_q       <= cu_ena_d;
            cap_pend_q     <= cap_pend_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            acc_q          <= acc_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        phase_d        = phase_q;
        hi_d           = hi_q;
        prog_len_d     = prog_len_q;
        drain_d        = drain_q;
        instr_d        = '0;
        cu_ena_d       = 1'b0;
        cap_pend_d     = cu_ena_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        acc_d          = acc_q;
        done_d         = 1'b0;
        mem_we_c       = 1'b0;

        // The compute unit registers an issued entry one cycle later; sample it then.
        if (cap_pend_q) begin
            result_d       = result_in;
            result_valid_d = 1'b1;
            acc_d          = acc_q ^ result_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d    = ST_LOAD;
                    wr_ptr_d   = '0;
                    phase_d    = 1'b0;
                    prog_len_d = '0;
                end else if (start && (prog_len_q != '0)) begin
                    state_d  = ST_RUN;
                    rd_ptr_d = '0;
                    acc_d    = '0;
                end
            end
            ST_LOAD: begin
                if (byte_valid) begin
                    if (!phase_q) begin
                        hi_d    = byte_in;
                        phase_d = 1'b1;
                    end else begin
                        mem_we_c   = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                        prog_len_d = prog_len_q + LEN_W'(1);
                        phase_d    = 1'b0;
                        if (is_nop(hi_q) || (prog_len_q == LEN_W'(DEPTH - 1))) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_RUN: begin
                instr_d  = mem_rdata_c;
                cu_ena_d = 1'b1;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (LEN_W'(rd_ptr_q) == (prog_len_q - LEN_W'(1))) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Two cycles let the final entry's result reach the capture register.
                if (drain_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Strobes are suppressed while stalled without disturbing the registers behind them.
    assign instr_out    = instr_q;
    assign cu_ena       = cu_ena_q & ena;
    assign busy         = busy_q;
    assign prog_len     = prog_len_q;
    assign result_out   = result_q;
    assign result_valid = result_valid_q & ena;
    assign acc_out      = acc_q;
    assign done         = done_q & ena;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer with a simple registered compute-unit model.
module tb_instr_issuer;
    import instr_issuer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        load;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [7:0]  result_in;
    logic [15:0] instr_out;
    logic        cu_ena;
    logic        busy;
    logic [3:0]  prog_len;
    logic [7:0]  result_out;
    logic        result_valid;
    logic [7:0]  acc_out;
    logic        done;

    instr_issuer #(.DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .load         (load),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .result_in    (result_in),
        .instr_out    (instr_out),
        .cu_ena       (cu_ena),
        .busy         (busy),
        .prog_len     (prog_len),
        .result_out   (result_out),
        .result_valid (result_valid),
        .acc_out      (acc_out),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Compute-unit behaviour used both by the model and for expected results.
    function automatic logic [7:0] cu_f(input logic [15:0] ins);
        logic [3:0] op;
        op = ins[15:12];
        case (op)
            OP_LOAD: return ins[7:0];
            OP_ADD:  return ins[15:8] + ins[7:0];
            OP_XOR:  return ins[15:8] ^ ins[7:0];
            default: return ins[7:0];
        endcase
    endfunction

    // Compute unit: registers its result on each enabled cycle.
    logic [7:0] cu_res = 8'h00;
    always @(posedge clk) begin
        if (cu_ena) cu_res <= cu_f(instr_out);
    end
    assign result_in = cu_res;

    // Monitor: records every qualified result and counts done pulses.
    logic [7:0] obs [0:63];
    int         obs_n    = 0;
    int         done_cnt = 0;
    always @(negedge clk) begin
        if (result_valid && obs_n < 64) begin
            obs[obs_n] = result_out;
            obs_n      = obs_n + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    int         n_vec = 0;
    int         n_err = 0;
    int         obs_rd = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare recorded results against the expected queue, in order.
    task automatic sb_check(input string nm);
        chk({nm, "_count"}, 32'(obs_n - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            chk({nm, "_result"}, 32'(obs[obs_rd]), 32'(exp_q.pop_front()));
            obs_rd = obs_rd + 1;
        end
        exp_q.delete();
        obs_rd = obs_n;
    endtask

    typedef struct {
        logic        load;
        logic        start;
        logic        bv;
        logic [7:0]  b;
        logic [15:0] e_instr;
        logic        e_cu;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_len;
    } vec_t;

    vec_t        vecs [12];
    logic [15:0] prog_a [2];
    logic [15:0] prog_f [8];

    initial begin
        logic [7:0] acc_exp;
        logic       found;
        int         d0;

        prog_a[0] = 16'h912A;
        prog_a[1] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            prog_f[i] = {8'h90 + 8'(i + 1), 8'((i + 1) * 19)};
        end

        //              load  start bv    byte   instr     cu    busy  done  len
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h91, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h2A, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h55, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h912A, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h77, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd2};

        rst_n = 1'b0; ena = 1'b1; load = 1'b0; start = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0;

        // Asynchronous reset: outputs clear before any clock edge.
        #3;
        chk("rst_instr",  32'(instr_out),    32'h0);
        chk("rst_cu_ena", 32'(cu_ena),       32'h0);
        chk("rst_busy",   32'(busy),         32'h0);
        chk("rst_len",    32'(prog_len),     32'h0);
        chk("rst_result", 32'(result_out),   32'h0);
        chk("rst_rvalid", 32'(result_valid), 32'h0);
        chk("rst_acc",    32'(acc_out),      32'h0);
        chk("rst_done",   32'(done),         32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short program load and run, one vector per cycle.
        for (int k = 0; k < 12; k++) begin
            load = vecs[k].load; start = vecs[k].start;
            byte_valid = vecs[k].bv; byte_in = vecs[k].b;
            if (vecs[k].start) begin
                for (int j = 0; j < 2; j++) exp_q.push_back(cu_f(prog_a[j]));
            end
            @(negedge clk);
            chk($sformatf("v%0d_instr", k), 32'(instr_out), 32'(vecs[k].e_instr));
            chk($sformatf("v%0d_cu_ena", k), 32'(cu_ena), 32'(vecs[k].e_cu));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
            chk($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].e_done));
            chk($sformatf("v%0d_len", k), 32'(prog_len), 32'(vecs[k].e_len));
        end
        load = 1'b0; start = 1'b0; byte_valid = 1'b0;
        chk("short_acc", 32'(acc_out), 32'h2A);
        sb_check("short_sb");

        // Full-depth load: 16 bytes end the load without a terminator.
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1; byte_in = prog_f[i][15:8];
            @(negedge clk);
            byte_in = prog_f[i][7:0];
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk("full_len", 32'(prog_len), 32'd8);
        chk("full_busy", 32'(busy), 32'd0);
        byte_valid = 1'b1; byte_in = 8'h00;
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("extra_byte_len", 32'(prog_len), 32'd8);
        chk("extra_byte_busy", 32'(busy), 32'd0);

        // Run with a 3-cycle stall after the fourth entry is presented.
        acc_exp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(cu_f(prog_f[i]));
            acc_exp = acc_exp ^ cu_f(prog_f[i]);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (cu_ena && instr_out == prog_f[3]) found = 1'b1;
            else @(negedge clk);
        end
        chk("stall_reach_entry3", 32'(found), 32'd1);
        ena = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_instr_held", 32'(instr_out), 32'(prog_f[3]));
            chk("stall_cu_ena", 32'(cu_ena), 32'd0);
            chk("stall_rvalid", 32'(result_valid), 32'd0);
        end
        ena = 1'b1;
        d0 = done_cnt;
        for (int c = 0; c < 40 && done_cnt == d0; c++) @(negedge clk);
        chk("stall_done_seen", 32'(done_cnt - d0), 32'd1);
        @(negedge clk);
        chk("stall_acc", 32'(acc_out), 32'(acc_exp));
        chk("stall_busy_end", 32'(busy), 32'd0);
        sb_check("stall_sb");

        // Reset in the middle of a run (program persisted from the full load).
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (cu_ena && instr_out == prog_f[3]) found = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reach_entry3", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cu_ena", 32'(cu_ena), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_len", 32'(prog_len), 32'd0);
        chk("abort_instr", 32'(instr_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_cu_ena", 32'(cu_ena), 32'd0);
        exp_q.delete();
        obs_rd = obs_n;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
